// File: rtl/usb_status_reporter.sv
// USB status debug monitor: watched status changes are reported as "S=XXXX\r\n" lines on an 8N1 UART.
// Optional macro USB_STATUS_DROP_MARK_EN: a line started while dropped=1 carries '*' before CR.
module usb_status_reporter #(
    parameter int          CLKS_PER_BIT = 416,
    parameter logic [12:0] WATCH_MASK   = 13'h1FE4
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       tx_j,
    input  logic       tx_se0,
    input  logic       usb_rst,
    input  logic       transaction_active,
    input  logic [3:0] endpoint,
    input  logic       direction_in,
    input  logic       setup,
    input  logic       data_strobe,
    input  logic       success,
    output logic       uart_sout,
    output logic       uart_busy,
    output logic       uart_done,
    output logic       dropped
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} state_t;

    state_t        state, state_n;
    logic [1:0]    rst_pipe;
    logic          rst_sync_n;
    logic [12:0]   sync1, snap, snap_prev;
    logic [12:0]   msg, pend;
    logic          pend_valid;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    data_idx;
    logic [3:0]    byte_idx, last_idx;
    logic          change, bit_end, start_msg, mark;
    logic [15:0]   hex_word;
    logic [7:0]    cur_byte;

    // Reset asserts asynchronously but releases two clocks later.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_sync_n = rst_pipe[1];

    always_ff @(posedge clk48 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sync1     <= '0;
            snap      <= '0;
            snap_prev <= '0;
        end else begin
            sync1     <= {success, data_strobe, setup, direction_in, endpoint,
                          transaction_active, usb_rst, tx_se0, tx_j, tx_en};
            snap      <= sync1;
            snap_prev <= snap;
        end
    end

    assign change    = |((snap ^ snap_prev) & WATCH_MASK);
    assign bit_end   = (bit_cnt == BIT_LAST);
    assign start_msg = ((state == IDLE) && change) || (state == LOAD);
    assign uart_busy = (state != IDLE);
    assign hex_word  = {3'b000, msg};
    assign last_idx  = mark ? 4'd8 : 4'd7;

`ifdef USB_STATUS_DROP_MARK_EN
    always_ff @(posedge clk48 or negedge rst_sync_n) begin
        if (!rst_sync_n)    mark <= 1'b0;
        else if (start_msg) mark <= dropped;
    end
`else
    assign mark = 1'b0;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            4'd0:    cur_byte = 8'h53;
            4'd1:    cur_byte = 8'h3D;
            4'd2:    cur_byte = hex_ascii(hex_word[15:12]);
            4'd3:    cur_byte = hex_ascii(hex_word[11:8]);
            4'd4:    cur_byte = hex_ascii(hex_word[7:4]);
            4'd5:    cur_byte = hex_ascii(hex_word[3:0]);
            4'd6:    cur_byte = mark ? 8'h2A : 8'h0D;
            4'd7:    cur_byte = mark ? 8'h0D : 8'h0A;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_n   = state;
        uart_sout = 1'b1;
        case (state)
            IDLE:  if (change) state_n = START;
            START: begin
                uart_sout = 1'b0;
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                uart_sout = cur_byte[data_idx];
                if (bit_end && data_idx == 3'd7) state_n = STOP;
            end
            STOP: begin
                // An event landing on the final stop cycle still goes through LOAD.
                if (bit_end) begin
                    if (byte_idx != last_idx)     state_n = START;
                    else if (pend_valid || change) state_n = LOAD;
                    else                           state_n = IDLE;
                end
            end
            LOAD:    state_n = START;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk48 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            data_idx   <= '0;
            byte_idx   <= '0;
            msg        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            dropped    <= 1'b0;
            uart_done  <= 1'b0;
        end else begin
            state     <= state_n;
            uart_done <= (state == STOP) && bit_end;
            if (state == IDLE || state == LOAD || bit_end) bit_cnt <= '0;
            else                                           bit_cnt <= bit_cnt + CW'(1);
            if (state == DATA && bit_end) data_idx <= data_idx + 3'd1;
            if (start_msg)                       byte_idx <= 4'd0;
            else if (state == STOP && bit_end)   byte_idx <= byte_idx + 4'd1;
            if (start_msg) begin
                msg     <= (state == LOAD) ? pend : snap;
                dropped <= 1'b0;
            end
            // In LOAD the old pending word is being consumed, so refilling it is not a drop.
            if (change && state != IDLE) begin
                pend       <= snap;
                pend_valid <= 1'b1;
                if (pend_valid && state != LOAD) dropped <= 1'b1;
            end else if (state == LOAD) begin
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_usb_status_reporter.sv
// Self-checking bench for usb_status_reporter: decodes the UART line and compares it with a line model.
module tb_usb_status_reporter;
    localparam int          CPB  = 4;
    localparam logic [12:0] MASK = 13'h1FE4;
`ifdef USB_STATUS_DROP_MARK_EN
    localparam bit MARK_EN = 1'b1;
`else
    localparam bit MARK_EN = 1'b0;
`endif

    logic       clk48 = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en, tx_j, tx_se0, usb_rst, transaction_active;
    logic [3:0] endpoint;
    logic       direction_in, setup, data_strobe, success;
    logic       uart_sout, uart_busy, uart_done, dropped;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, busy_total = 0, busy_run = 0, last_run = 0, frame_err = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [12:0] model_s = '0;

    usb_status_reporter #(.CLKS_PER_BIT(CPB), .WATCH_MASK(MASK)) dut (
        .clk48(clk48), .rst_n(rst_n),
        .tx_en(tx_en), .tx_j(tx_j), .tx_se0(tx_se0), .usb_rst(usb_rst),
        .transaction_active(transaction_active), .endpoint(endpoint),
        .direction_in(direction_in), .setup(setup), .data_strobe(data_strobe),
        .success(success),
        .uart_sout(uart_sout), .uart_busy(uart_busy), .uart_done(uart_done),
        .dropped(dropped)
    );

    always #5 clk48 = ~clk48;

    // UART receiver: samples each bit near its middle on falling clock edges.
    initial begin : uart_rx
        logic [7:0] b;
        forever begin
            @(negedge clk48);
            if (rst_n === 1'b1 && uart_sout === 1'b0) begin
                repeat (CPB / 2) @(negedge clk48);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk48);
                    b[i] = uart_sout;
                end
                repeat (CPB) @(negedge clk48);
                if (uart_sout !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    always @(negedge clk48) begin
        if (uart_done === 1'b1) done_cnt++;
        if (uart_busy === 1'b1) begin
            busy_run++;
            busy_total++;
        end else begin
            if (busy_run != 0) last_run = busy_run;
            busy_run = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [12:0] pack_inputs();
        return {success, data_strobe, setup, direction_in, endpoint,
                transaction_active, usb_rst, tx_se0, tx_j, tx_en};
    endfunction

    task automatic set_inputs(input logic [12:0] s);
        {success, data_strobe, setup, direction_in, endpoint,
         transaction_active, usb_rst, tx_se0, tx_j, tx_en} = s;
    endtask

    function automatic logic [7:0] hex_char(input int d);
        return (d < 10) ? 8'(48 + d) : 8'(55 + d);
    endfunction

    // Reference line: "S=" + 4 hex digits of the zero-extended word (+ '*') + CR LF.
    task automatic expect_line(input logic [12:0] s, input bit mark);
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h3D);
        for (int k = 3; k >= 0; k--) exp_q.push_back(hex_char((int'(s) >> (4 * k)) & 15));
        if (mark) exp_q.push_back(8'h2A);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    function automatic string dump(input bit use_rx);
        string s = "";
        int n = use_rx ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) s = {s, $sformatf(" %02h", use_rx ? rx_q[i] : exp_q[i])};
        return s;
    endfunction

    task automatic wait_rise(output bit ok);
        int n = 0;
        while (uart_busy !== 1'b1 && n < 40) begin
            @(negedge clk48);
            n++;
        end
        ok = (uart_busy === 1'b1);
    endtask

    task automatic wait_quiet(output bit ok);
        int quiet = 0;
        int n = 0;
        repeat (12) @(negedge clk48);
        while (quiet < 60 && n < 8000) begin
            @(negedge clk48);
            n++;
            if (uart_busy === 1'b1) quiet = 0;
            else quiet++;
        end
        ok = (quiet >= 60);
    endtask

    task automatic test_reset();
        int d0, low_cnt, b0;
        set_inputs('0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk48);
        checks++; if (uart_sout !== 1'b1) begin errors++; $display("[TB] FAIL rst_sout got %b want 1", uart_sout); end
        checks++; if (uart_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b want 0", uart_busy); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("[TB] FAIL rst_dropped got %b want 0", dropped); end
        checks++; if (uart_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got %b want 0", uart_done); end
        rst_n = 1'b1;
        d0 = done_cnt;
        b0 = busy_total;
        low_cnt = 0;
        repeat (1000) begin
            @(negedge clk48);
            if (uart_sout !== 1'b1) low_cnt++;
        end
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("[TB] FAIL idle_done got %0d want 0", done_cnt - d0); end
        checks++; if (low_cnt != 0) begin errors++; $display("[TB] FAIL idle_sout_low got %0d want 0", low_cnt); end
        checks++; if (busy_total - b0 != 0) begin errors++; $display("[TB] FAIL idle_busy got %0d want 0", busy_total - b0); end
        model_s = '0;
    endtask

    task automatic test_setup();
        bit ok;
        int d0;
        string got, want;
        rx_q.delete(); exp_q.delete();
        d0 = done_cnt;
        setup = 1'b1;
        model_s = pack_inputs();
        expect_line(model_s, 1'b0);
        wait_rise(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL setup_rise got 0 want 1"); end
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL setup_quiet got 0 want 1"); end
        checks++; if (last_run != 80 * CPB) begin errors++; $display("[TB] FAIL setup_busy_len got %0d want %0d", last_run, 80 * CPB); end
        checks++; if (done_cnt - d0 != 8) begin errors++; $display("[TB] FAIL setup_done got %0d want 8", done_cnt - d0); end
        got = dump(1); want = dump(0);
        checks++; if (got != want) begin errors++; $display("[TB] FAIL setup_line got%s want%s", got, want); end
    endtask

    task automatic test_endpoint();
        bit ok;
        string got, want;
        rx_q.delete(); exp_q.delete();
        endpoint = 4'h3;
        transaction_active = 1'b1;
        model_s = pack_inputs();
        expect_line(model_s, 1'b0);
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL endpoint_quiet got 0 want 1"); end
        got = dump(1); want = dump(0);
        checks++; if (got != want) begin errors++; $display("[TB] FAIL endpoint_line got%s want%s", got, want); end
    endtask

    task automatic test_unwatched();
        int b0, d0;
        rx_q.delete();
        b0 = busy_total;
        d0 = done_cnt;
        repeat (300) begin
            @(negedge clk48);
            tx_j = ~tx_j;
            tx_en = ~tx_en;
            usb_rst = ~usb_rst;
        end
        repeat (100) @(negedge clk48);
        checks++; if (busy_total - b0 != 0) begin errors++; $display("[TB] FAIL unwatched_busy got %0d want 0", busy_total - b0); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL unwatched_bytes got %0d want 0", rx_q.size()); end
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("[TB] FAIL unwatched_done got %0d want 0", done_cnt - d0); end
        model_s = pack_inputs();
    endtask

    task automatic test_drop();
        bit ok;
        int want_len;
        string got, want;
        rx_q.delete(); exp_q.delete();
        endpoint = 4'h1;
        expect_line(pack_inputs(), 1'b0);
        wait_rise(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL drop_rise got 0 want 1"); end
        repeat (20) @(negedge clk48);
        endpoint = 4'h2;
        repeat (20) @(negedge clk48);
        checks++; if (dropped !== 1'b0) begin errors++; $display("[TB] FAIL drop_one_pending got %b want 0", dropped); end
        endpoint = 4'h5;
        model_s = pack_inputs();
        expect_line(model_s, MARK_EN);
        repeat (10) @(negedge clk48);
        checks++; if (dropped !== 1'b1) begin errors++; $display("[TB] FAIL drop_set got %b want 1", dropped); end
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL drop_quiet got 0 want 1"); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("[TB] FAIL drop_clear got %b want 0", dropped); end
        want_len = 80 * CPB + (MARK_EN ? 90 : 80) * CPB + 1;
        checks++; if (last_run != want_len) begin errors++; $display("[TB] FAIL drop_busy_len got %0d want %0d", last_run, want_len); end
        got = dump(1); want = dump(0);
        checks++; if (got != want) begin errors++; $display("[TB] FAIL drop_lines got%s want%s", got, want); end
    endtask

    task automatic test_back_to_back();
        bit ok, rose;
        string got, want;
        for (int off = 310; off <= 326; off++) begin
            rx_q.delete(); exp_q.delete();
            endpoint = 4'((2 * off) & 15);
            expect_line(pack_inputs(), 1'b0);
            wait_rise(rose);
            repeat (off) @(negedge clk48);
            endpoint = 4'((2 * off + 1) & 15);
            model_s = pack_inputs();
            expect_line(model_s, 1'b0);
            wait_quiet(ok);
            got = dump(1); want = dump(0);
            checks++;
            if (!(rose && ok) || got != want) begin
                errors++;
                $display("[TB] FAIL b2b_off%0d rise=%b quiet=%b got%s want%s", off, rose, ok, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int b0, d0;
        string got, want;
        endpoint = 4'hA;
        wait_rise(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rstmid_rise got 0 want 1"); end
        repeat (5 * CPB + 1) @(negedge clk48);
        rst_n = 1'b0;
        #1;
        checks++; if (uart_sout !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_sout got %b want 1", uart_sout); end
        checks++; if (uart_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", uart_busy); end
        set_inputs('0);
        repeat (60) @(negedge clk48);
        rx_q.delete(); exp_q.delete();
        rst_n = 1'b1;
        model_s = '0;
        b0 = busy_total;
        d0 = done_cnt;
        repeat (300) @(negedge clk48);
        checks++; if (busy_total - b0 != 0 || rx_q.size() != 0 || done_cnt - d0 != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_idle got busy=%0d bytes=%0d done=%0d want 0 0 0", busy_total - b0, rx_q.size(), done_cnt - d0);
        end
        setup = 1'b1;
        model_s = pack_inputs();
        expect_line(model_s, 1'b0);
        wait_quiet(ok);
        got = dump(1); want = dump(0);
        checks++; if (got != want) begin errors++; $display("[TB] FAIL rstmid_line got%s want%s", got, want); end
    endtask

    task automatic test_random();
        bit ok;
        logic [12:0] s;
        string got, want;
        for (int it = 0; it < 24; it++) begin
            rx_q.delete(); exp_q.delete();
            s = 13'($urandom);
            if ($urandom_range(0, 1) == 0) s = (model_s & MASK) | (s & ~MASK);
            set_inputs(s);
            if (((s ^ model_s) & MASK) != 0) expect_line(s, 1'b0);
            model_s = s;
            wait_quiet(ok);
            got = dump(1); want = dump(0);
            checks++;
            if (!ok || got != want) begin
                errors++;
                $display("[TB] FAIL random_%0d s=%04h quiet=%b got%s want%s", it, s, ok, got, want);
            end
        end
    endtask

    task automatic test_framing();
        checks++; if (frame_err != 0) begin errors++; $display("[TB] FAIL stop_bits got %0d bad want 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_setup();
        test_endpoint();
        test_unwatched();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_framing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
